// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the two-requester qspi flash transaction arbiter.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int unsigned TO_CYC_DEFAULT = 50000;

endpackage

// File: rtl/qspi_arb_timer.sv
// Readback watchdog: clearable, enabled, saturating up-counter that flags TO_CYC-1.
module qspi_arb_timer
  import qspi_arb_pkg::*;
#(
  parameter int unsigned          TO_BITS = 16,
  parameter logic [TO_BITS-1:0]   TO_CYC  = TO_BITS'(TO_CYC_DEFAULT)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TO_BITS-1:0] TC_VAL = TO_CYC - TO_BITS'(1);

  logic [TO_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + TO_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/qspi_flash_arb.sv
// Grants one of two requesters a whole flash transaction (command packet plus
// optional readback packet) with round-robin tie-breaking and a readback timeout.
module qspi_flash_arb
  import qspi_arb_pkg::*;
#(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          TO_BITS = 16,
  parameter logic [TO_BITS-1:0]   TO_CYC  = TO_BITS'(TO_CYC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s0_cmd_data,
  input  logic              s0_cmd_tlast,
  input  logic              s0_cmd_rsp,
  input  logic              s0_cmd_valid,
  output logic              s0_cmd_ready,
  input  logic [DATA_W-1:0] s1_cmd_data,
  input  logic              s1_cmd_tlast,
  input  logic              s1_cmd_rsp,
  input  logic              s1_cmd_valid,
  output logic              s1_cmd_ready,
  output logic [DATA_W-1:0] m_cmd_data,
  output logic              m_cmd_tlast,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  input  logic [DATA_W-1:0] m_rsp_data,
  input  logic              m_rsp_tlast,
  input  logic              m_rsp_valid,
  output logic              m_rsp_ready,
  output logic [DATA_W-1:0] s0_rsp_data,
  output logic              s0_rsp_tlast,
  output logic              s0_rsp_valid,
  input  logic              s0_rsp_ready,
  output logic [DATA_W-1:0] s1_rsp_data,
  output logic              s1_rsp_tlast,
  output logic              s1_rsp_valid,
  input  logic              s1_rsp_ready,
  output logic [1:0]        grant,
  output logic [1:0]        to_err
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] to_err_q, to_err_d;
  logic       rr_last_q, rr_last_d;
  logic       rsp_exp_q, rsp_exp_d;
  logic       first_q, first_d;

  logic owner, winner;
  logic in_cmd, in_rsp;
  logic own_cmd_valid, own_cmd_tlast, own_cmd_rsp, own_rsp_ready;
  logic cmd_hs, rsp_hs, rsp_now, timeout;
  logic tmr_clr, tmr_en, tmr_tc;

  assign owner  = grant_q[1];
  assign in_cmd = (state_q == ST_CMD);
  assign in_rsp = (state_q == ST_RSP);

  // On a tie the requester that did not win last time goes next.
  assign winner = (s0_cmd_valid && s1_cmd_valid) ? ~rr_last_q : s1_cmd_valid;

  assign own_cmd_valid = (owner == REQ1) ? s1_cmd_valid : s0_cmd_valid;
  assign own_cmd_tlast = (owner == REQ1) ? s1_cmd_tlast : s0_cmd_tlast;
  assign own_cmd_rsp   = (owner == REQ1) ? s1_cmd_rsp   : s0_cmd_rsp;
  assign own_rsp_ready = (owner == REQ1) ? s1_rsp_ready : s0_rsp_ready;

  assign m_cmd_valid  = in_cmd && own_cmd_valid;
  assign m_cmd_tlast  = in_cmd && own_cmd_tlast;
  assign m_cmd_data   = (owner == REQ1) ? s1_cmd_data : s0_cmd_data;
  assign s0_cmd_ready = in_cmd && (owner == REQ0) && m_cmd_ready;
  assign s1_cmd_ready = in_cmd && (owner == REQ1) && m_cmd_ready;

  // Idle keeps the flash drained so late beats from an aborted read are dropped.
  assign m_rsp_ready  = (state_q == ST_IDLE) || (in_rsp && own_rsp_ready);
  assign s0_rsp_valid = in_rsp && (owner == REQ0) && m_rsp_valid;
  assign s1_rsp_valid = in_rsp && (owner == REQ1) && m_rsp_valid;
  assign s0_rsp_tlast = in_rsp && (owner == REQ0) && m_rsp_tlast;
  assign s1_rsp_tlast = in_rsp && (owner == REQ1) && m_rsp_tlast;
  assign s0_rsp_data  = m_rsp_data;
  assign s1_rsp_data  = m_rsp_data;

  assign cmd_hs  = m_cmd_valid && m_cmd_ready;
  assign rsp_hs  = in_rsp && m_rsp_valid && own_rsp_ready;
  assign rsp_now = first_q ? own_cmd_rsp : rsp_exp_q;
  assign timeout = in_rsp && tmr_tc && !rsp_hs;

  assign tmr_clr = !in_rsp || rsp_hs;
  assign tmr_en  = in_rsp && !m_rsp_valid;

  qspi_arb_timer #(
    .TO_BITS (TO_BITS),
    .TO_CYC  (TO_CYC)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .tc      (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    to_err_d  = '0;
    rr_last_d = rr_last_q;
    rsp_exp_d = rsp_exp_q;
    first_d   = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_cmd_valid || s1_cmd_valid) begin
          grant_d   = winner ? 2'b10 : 2'b01;
          rr_last_d = winner;
          first_d   = 1'b1;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_hs) begin
          first_d = 1'b0;
          if (first_q) begin
            rsp_exp_d = own_cmd_rsp;
          end
          if (own_cmd_tlast) begin
            if (rsp_now) begin
              state_d = ST_RSP;
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
            end
          end
        end
      end
      ST_RSP: begin
        if (rsp_hs && m_rsp_tlast) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (timeout) begin
          to_err_d = grant_q;
          state_d  = ST_IDLE;
          grant_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      to_err_q  <= '0;
      rr_last_q <= 1'b1;
      rsp_exp_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      to_err_q  <= to_err_d;
      rr_last_q <= rr_last_d;
      rsp_exp_q <= rsp_exp_d;
      first_q   <= first_d;
    end
  end

  assign grant  = grant_q;
  assign to_err = to_err_q;

endmodule

// File: tb/tb_qspi_flash_arb.sv
// Directed self-checking bench for qspi_flash_arb, built with an 8-cycle readback timeout.
module tb_qspi_flash_arb;

  logic       clk;
  logic       reset_n;
  logic [7:0] s0_cmd_data, s1_cmd_data, m_cmd_data;
  logic       s0_cmd_tlast, s0_cmd_rsp, s0_cmd_valid, s0_cmd_ready;
  logic       s1_cmd_tlast, s1_cmd_rsp, s1_cmd_valid, s1_cmd_ready;
  logic       m_cmd_tlast, m_cmd_valid, m_cmd_ready;
  logic [7:0] m_rsp_data, s0_rsp_data, s1_rsp_data;
  logic       m_rsp_tlast, m_rsp_valid, m_rsp_ready;
  logic       s0_rsp_tlast, s0_rsp_valid, s0_rsp_ready;
  logic       s1_rsp_tlast, s1_rsp_valid, s1_rsp_ready;
  logic [1:0] grant, to_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] pkt [8];

  qspi_flash_arb #(
    .DATA_W  (8),
    .TO_BITS (16),
    .TO_CYC  (16'd8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s0_cmd_data  (s0_cmd_data),
    .s0_cmd_tlast (s0_cmd_tlast),
    .s0_cmd_rsp   (s0_cmd_rsp),
    .s0_cmd_valid (s0_cmd_valid),
    .s0_cmd_ready (s0_cmd_ready),
    .s1_cmd_data  (s1_cmd_data),
    .s1_cmd_tlast (s1_cmd_tlast),
    .s1_cmd_rsp   (s1_cmd_rsp),
    .s1_cmd_valid (s1_cmd_valid),
    .s1_cmd_ready (s1_cmd_ready),
    .m_cmd_data   (m_cmd_data),
    .m_cmd_tlast  (m_cmd_tlast),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .m_rsp_data   (m_rsp_data),
    .m_rsp_tlast  (m_rsp_tlast),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_ready  (m_rsp_ready),
    .s0_rsp_data  (s0_rsp_data),
    .s0_rsp_tlast (s0_rsp_tlast),
    .s0_rsp_valid (s0_rsp_valid),
    .s0_rsp_ready (s0_rsp_ready),
    .s1_rsp_data  (s1_rsp_data),
    .s1_rsp_tlast (s1_rsp_tlast),
    .s1_rsp_valid (s1_rsp_valid),
    .s1_rsp_ready (s1_rsp_ready),
    .grant        (grant),
    .to_err       (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input int req, input logic v, input logic [7:0] d,
                           input logic l, input logic r);
    if (req == 0) begin
      s0_cmd_valid = v; s0_cmd_data = d; s0_cmd_tlast = l; s0_cmd_rsp = r;
    end else begin
      s1_cmd_valid = v; s1_cmd_data = d; s1_cmd_tlast = l; s1_cmd_rsp = r;
    end
  endtask

  // Sends pkt[0..len-1] from one requester; every accepted beat is checked once.
  task automatic applyStimulus(input int req, input int len, input logic rsp, input bit stall);
    logic [1:0] gexp;
    bit done;
    gexp = (req == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < len; i++) begin
      drive_cmd(req, 1'b1, pkt[i], (i == len - 1), rsp);
      done = 1'b0;
      for (int g = 0; g < 60 && !done; g++) begin
        if (stall) m_cmd_ready = 1'($urandom_range(0, 1));
        #1;
        if (m_cmd_valid && m_cmd_ready) begin
          checkOutput("cmd_data", 32'(m_cmd_data), 32'(pkt[i]));
          checkOutput("cmd_tlast", 32'(m_cmd_tlast), 32'(i == len - 1));
          checkOutput("cmd_grant", 32'(grant), 32'(gexp));
          checkOutput("cmd_other_ready", 32'(req == 0 ? s1_cmd_ready : s0_cmd_ready), 32'(0));
          done = 1'b1;
        end
        tick();
      end
      checkOutput("cmd_hs_bound", 32'(done), 32'(1));
    end
    drive_cmd(req, 1'b0, 8'h00, 1'b0, 1'b0);
    m_cmd_ready = 1'b1;
  endtask

  // Flash returns len bytes base, base+1, ...; gap idle cycles between beats.
  task automatic flashRespond(input int req, input int len, input logic [7:0] base,
                              input bit stall, input int gap);
    logic own_ready;
    bit done;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        m_rsp_valid = 1'b0;
        for (int k = 0; k < gap; k++) tick();
        checkOutput("gap_to_err", 32'(to_err), 32'(0));
      end
      m_rsp_valid = 1'b1;
      m_rsp_data  = base + 8'(i);
      m_rsp_tlast = (i == len - 1);
      done = 1'b0;
      for (int g = 0; g < 60 && !done; g++) begin
        own_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (req == 0) s0_rsp_ready = own_ready; else s1_rsp_ready = own_ready;
        #1;
        checkOutput("rsp_to_err", 32'(to_err), 32'(0));
        checkOutput("rsp_other_valid", 32'(req == 0 ? s1_rsp_valid : s0_rsp_valid), 32'(0));
        checkOutput("rsp_own_valid", 32'(req == 0 ? s0_rsp_valid : s1_rsp_valid), 32'(1));
        checkOutput("rsp_m_ready", 32'(m_rsp_ready), 32'(own_ready));
        if (own_ready) begin
          checkOutput("rsp_data", 32'(req == 0 ? s0_rsp_data : s1_rsp_data), 32'(base + 8'(i)));
          checkOutput("rsp_tlast", 32'(req == 0 ? s0_rsp_tlast : s1_rsp_tlast), 32'(i == len - 1));
          done = 1'b1;
        end
        tick();
      end
      checkOutput("rsp_hs_bound", 32'(done), 32'(1));
    end
    m_rsp_valid = 1'b0;
    m_rsp_tlast = 1'b0;
    s0_rsp_ready = 1'b1;
    s1_rsp_ready = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_cmd(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive_cmd(1, 1'b0, 8'h00, 1'b0, 1'b0);
    m_cmd_ready = 1'b1;
    m_rsp_data = 8'h00; m_rsp_tlast = 1'b0; m_rsp_valid = 1'b0;
    s0_rsp_ready = 1'b1; s1_rsp_ready = 1'b1;
    #2;
    checkOutput("rst_grant", 32'(grant), 32'(0));
    checkOutput("rst_to_err", 32'(to_err), 32'(0));
    checkOutput("rst_m_cmd_valid", 32'(m_cmd_valid), 32'(0));
    checkOutput("rst_s0_cmd_ready", 32'(s0_cmd_ready), 32'(0));
    checkOutput("rst_s1_cmd_ready", 32'(s1_cmd_ready), 32'(0));
    checkOutput("rst_s0_rsp_valid", 32'(s0_rsp_valid), 32'(0));
    checkOutput("rst_s1_rsp_valid", 32'(s1_rsp_valid), 32'(0));
    checkOutput("rst_m_rsp_ready", 32'(m_rsp_ready), 32'(1));
    tick();
    reset_n = 1'b1;
    tick();

    // Single command without readback from requester 0.
    pkt[0] = 8'h06; pkt[1] = 8'h00; pkt[2] = 8'h01;
    applyStimulus(0, 3, 1'b0, 1'b0);
    checkOutput("wr_grant_idle", 32'(grant), 32'(0));
    checkOutput("wr_cmd_valid_idle", 32'(m_cmd_valid), 32'(0));

    // Read from requester 1.
    pkt[0] = 8'h03; pkt[1] = 8'hA2; pkt[2] = 8'hA1; pkt[3] = 8'hA0;
    applyStimulus(1, 4, 1'b1, 1'b0);
    checkOutput("rd_grant_rsp", 32'(grant), 32'(2'b10));
    flashRespond(1, 4, 8'h11, 1'b0, 0);
    checkOutput("rd_grant_idle", 32'(grant), 32'(0));

    // Both requesters continuously valid: strict alternation starting with requester 0.
    drive_cmd(0, 1'b1, 8'hA0, 1'b1, 1'b0);
    drive_cmd(1, 1'b1, 8'hB1, 1'b1, 1'b0);
    for (int t = 0; t < 10; t++) begin
      bit seen;
      seen = 1'b0;
      for (int g = 0; g < 10 && !seen; g++) begin
        #1;
        if (m_cmd_valid && m_cmd_ready) begin
          checkOutput("alt_grant", 32'(grant), 32'((t % 2 == 0) ? 2'b01 : 2'b10));
          checkOutput("alt_data", 32'(m_cmd_data), 32'((t % 2 == 0) ? 8'hA0 : 8'hB1));
          seen = 1'b1;
        end
        tick();
      end
      checkOutput("alt_hs_bound", 32'(seen), 32'(1));
    end
    drive_cmd(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive_cmd(1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Back-pressure: random command stalls, long owner stall, random readback stalls.
    pkt[0] = 8'h0B; pkt[1] = 8'h12; pkt[2] = 8'h34; pkt[3] = 8'h56; pkt[4] = 8'h00;
    applyStimulus(0, 5, 1'b1, 1'b1);
    s0_rsp_ready = 1'b0;
    m_rsp_valid = 1'b1; m_rsp_data = 8'h40; m_rsp_tlast = 1'b0;
    repeat (12) tick();
    checkOutput("stall_to_err", 32'(to_err), 32'(0));
    checkOutput("stall_grant", 32'(grant), 32'(2'b01));
    checkOutput("stall_m_rsp_ready", 32'(m_rsp_ready), 32'(0));
    s0_rsp_ready = 1'b1;
    flashRespond(0, 6, 8'h40, 1'b1, 3);
    checkOutput("bp_grant_idle", 32'(grant), 32'(0));

    // Timeout: requester 0 read, flash silent.
    pkt[0] = 8'h0B; pkt[1] = 8'h00;
    applyStimulus(0, 2, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("to_wait_err", 32'(to_err), 32'(0));
      checkOutput("to_wait_grant", 32'(grant), 32'(2'b01));
    end
    tick();
    checkOutput("to_pulse", 32'(to_err), 32'(2'b01));
    checkOutput("to_grant", 32'(grant), 32'(0));
    tick();
    checkOutput("to_pulse_end", 32'(to_err), 32'(0));
    m_rsp_valid = 1'b1; m_rsp_data = 8'hEE; m_rsp_tlast = 1'b0;
    #1;
    checkOutput("late_m_ready0", 32'(m_rsp_ready), 32'(1));
    checkOutput("late_s0_valid0", 32'(s0_rsp_valid), 32'(0));
    tick();
    m_rsp_data = 8'hEF; m_rsp_tlast = 1'b1;
    #1;
    checkOutput("late_m_ready1", 32'(m_rsp_ready), 32'(1));
    checkOutput("late_s0_valid1", 32'(s0_rsp_valid), 32'(0));
    tick();
    m_rsp_valid = 1'b0; m_rsp_tlast = 1'b0;
    pkt[0] = 8'h05;
    applyStimulus(1, 1, 1'b1, 1'b0);
    flashRespond(1, 1, 8'h5A, 1'b0, 0);
    checkOutput("post_to_grant", 32'(grant), 32'(0));

    // Reset in the middle of a command packet.
    drive_cmd(0, 1'b1, 8'h9F, 1'b0, 1'b0);
    tick();
    checkOutput("mid_grant", 32'(grant), 32'(2'b01));
    tick();
    drive_cmd(0, 1'b1, 8'h01, 1'b0, 1'b0);
    #1;
    checkOutput("mid_cmd_valid", 32'(m_cmd_valid), 32'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_grant", 32'(grant), 32'(0));
    checkOutput("mid_rst_to_err", 32'(to_err), 32'(0));
    checkOutput("mid_rst_cmd_valid", 32'(m_cmd_valid), 32'(0));
    checkOutput("mid_rst_s0_ready", 32'(s0_cmd_ready), 32'(0));
    drive_cmd(0, 1'b1, 8'hA7, 1'b1, 1'b0);
    drive_cmd(1, 1'b1, 8'hB7, 1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_grant", 32'(grant), 32'(2'b01));
    checkOutput("post_rst_data", 32'(m_cmd_data), 32'(8'hA7));
    checkOutput("post_rst_valid", 32'(m_cmd_valid), 32'(1));
    drive_cmd(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive_cmd(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_flash_arb.md
Name: qspi_flash_arb

Overview:
- Two-requester transaction arbiter in front of the qspi_flash byte-stream command/readback interface.
- Typical requesters: the UL command path (port 0) and a boot/XIP prefetch engine (port 1).
- Grants one requester a whole flash transaction: the command packet, then the optional readback packet. Readback beats are routed only to the owner.
- Adds a readback timeout so a lost response cannot deadlock the flash.
- Sits in the clk domain, upstream of the cmd/readback FIFOs.

Parameters:
- DATA_W, 8, byte-stream data width.
- TO_BITS, 16, width of the readback timeout counter.
- TO_CYC, 16'd50000, cycles without a readback beat before the transaction is aborted; must be ≥1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- s0_cmd_data  in  DATA_W  requester 0 command byte.
- s0_cmd_tlast  in  1  last byte of the requester 0 command packet.
- s0_cmd_rsp  in  1  requester 0 expects a readback packet; sampled with the first command beat.
- s0_cmd_valid  in  1  requester 0 command valid.
- s0_cmd_ready  out  1  requester 0 command ready.
- s1_cmd_data, s1_cmd_tlast, s1_cmd_rsp, s1_cmd_valid, s1_cmd_ready: same as s0_* for requester 1.
- m_cmd_data  out  DATA_W  command byte to the flash.
- m_cmd_tlast  out  1  last command byte to the flash.
- m_cmd_valid  out  1  command valid to the flash.
- m_cmd_ready  in  1  command ready from the flash.
- m_rsp_data  in  DATA_W  readback byte from the flash.
- m_rsp_tlast  in  1  last readback byte.
- m_rsp_valid  in  1  readback valid.
- m_rsp_ready  out  1  readback ready to the flash.
- s0_rsp_data  out  DATA_W  readback byte to requester 0.
- s0_rsp_tlast  out  1  last readback byte to requester 0.
- s0_rsp_valid  out  1  readback valid to requester 0.
- s0_rsp_ready  in  1  requester 0 readback ready.
- s1_rsp_*: same as s0_rsp_* for requester 1.
- grant  out  2  one-hot owner; 0 when idle.
- to_err  out  2  one-cycle pulse on the owner's bit when its transaction times out.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE, grant=0, to_err=0, rr_last=1 (requester 0 wins the first tie), timer=0.
  - All *_valid outputs are 0; all s*_cmd_ready are 0.
- States:
  - IDLE
  - CMD: stream command beats.
  - RSP: route readback.
- IDLE:
  - If no s*_cmd_valid, stay.
  - If exactly one is valid, grant it.
  - If both are valid, grant the requester other than rr_last.
  - grant is registered; next state is CMD; rr_last is updated to the winner.
  - While in IDLE, m_rsp_ready=1 and stray readback beats are dropped.
- CMD:
  - Combinational pass-through: m_cmd_* = owner's s_cmd_*; owner's s_cmd_ready = m_cmd_ready; the other requester's ready = 0.
  - rsp_exp is latched from the owner's s_cmd_rsp on the first accepted beat.
  - On an accepted beat with tlast:
    - rsp_exp=0: go to IDLE, grant=0.
    - rsp_exp=1: go to RSP, timer cleared.
  - An owner deasserting valid mid-packet keeps the grant; there is no timeout in CMD.
- RSP:
  - Owner's s_rsp_* = m_rsp_*; m_rsp_ready = owner's s_rsp_ready.
  - Non-owner s_rsp_valid = 0.
  - On an accepted beat with tlast: go to IDLE, grant=0.
  - Timer behaviour:
    - Cleared on every accepted readback beat.
    - Increments when m_rsp_valid=0.
    - Holds when the owner is back-pressuring (m_rsp_valid=1, ready=0).
    - At timer==TO_CYC-1 with no beat accepted that cycle: to_err[owner] pulses for 1 cycle, state goes to IDLE, grant=0, and the remaining packet is drained by the IDLE drop rule.
- Back-to-back transactions:
  - Returning to IDLE costs one cycle.
  - Minimum gap between the tlast handshake and the next first beat is 2 cycles.
  - The same requester may win again only if the other is not valid in IDLE.
- Timer arithmetic is unsigned TO_BITS wide and saturates; there is no wrap.
- No combinational path from m_cmd_ready to m_cmd_valid.

Decomposition:
- Package qspi_arb_pkg holds:
  - the state enum (IDLE, CMD, RSP);
  - constants REQ0=0 and REQ1=1;
  - the default TO_CYC.
- One natural sub-module: qspi_arb_timer, a clear/enable/saturating counter with a terminal-count output, parameterised by TO_BITS and TO_CYC.

Test Plan:
- Single command, no response: requester 0 sends 3 bytes 0x06,0x00,0x01, tlast on the last, rsp=0, m_cmd_ready=1 → m_cmd shows the 3 bytes in order; grant=01 during CMD; grant=00 one cycle after tlast.
- Read transaction: requester 1 sends 0x03,A2,A1,A0 with rsp=1; flash returns 4 bytes 0x11..0x14 → only s1_rsp_valid pulses and the data matches; s0_rsp_valid stays 0; grant returns to 0 after the response tlast.
- Contention: both requesters valid at reset release → requester 0 granted first, requester 1 second; then both valid again → requester 0; strict alternation holds over 10 transactions.
- Back-pressure: toggle m_cmd_ready and s0_rsp_ready at random → no lost or duplicated bytes; timer holds while the owner stalls and to_err is never raised.
- Timeout: TO_CYC=8, requester 0 read with no flash response → to_err=01 pulses 1 cycle at the 8th idle cycle; grant=0; a late 2-byte response is dropped with m_rsp_ready=1; requester 1 is then served normally.
- Reset mid-transaction: assert reset_n low during CMD byte 2 → all valids, grant and to_err are 0 immediately; after release, the next transaction proceeds from IDLE with requester 0 priority.
